// File: rtl/mod12_counter.sv
// Purpose: loadable up/down modulo-MODULUS counter; out-of-range loads are forced to zero.
// Latency: every control input affects dout one clock after it is sampled.
// Backpressure: none; the counter updates on every edge and dout is read every clock.
module mod12_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             up_down,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Bounds held one bit wider than the count so that the increment and
  // decrement can be compared without any wrap at the WIDTH boundary.
  localparam logic [WIDTH:0] MAX_VAL = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0] ONE     = (WIDTH+1)'(1);

  logic [WIDTH-1:0] dout_d;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH:0]   din_ext;
  logic [WIDTH:0]   cur_ext;
  logic [WIDTH:0]   inc_ext;

  assign din_ext = {1'b0, din};
  assign cur_ext = {1'b0, dout_q};
  assign inc_ext = cur_ext + ONE;

  // Next count: load wins over counting; both directions wrap explicitly at the modulus.
  always_comb begin
    dout_d = dout_q;
    if (load) begin
      if (din_ext <= MAX_VAL) begin
        dout_d = din;
      end else begin
        dout_d = '0;
      end
    end else if (up_down) begin
      if (inc_ext > MAX_VAL) begin
        dout_d = '0;
      end else begin
        dout_d = inc_ext[WIDTH-1:0];
      end
    end else begin
      if (cur_ext == '0) begin
        dout_d = MAX_VAL[WIDTH-1:0];
      end else begin
        dout_d = dout_q - WIDTH'(1);
      end
    end
  end

  // Count register; reset is synchronous and overrides load and count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_mod12_counter.sv
module tb_mod12_counter;

  logic       clk;
  logic       rst;
  logic       load;
  logic       up_down;
  logic [3:0] din;
  logic [3:0] dout;

  int checks;
  int errors;

  mod12_counter #(.WIDTH(4), .MODULUS(12)) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .up_down (up_down),
    .din     (din),
    .dout    (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, take the edge, then compare dout just after it.
  task automatic step(input logic r, input logic l, input logic ud,
                      input logic [3:0] d, input logic [3:0] exp, input string tag);
    rst     = r;
    load    = l;
    up_down = ud;
    din     = d;
    @(posedge clk);
    #1;
    checks++;
    assert (dout === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, dout, exp);
    end
  endtask

  logic [3:0] model;
  logic       r_r, r_l, r_ud;
  logic [3:0] r_d;

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    load    = 1'b0;
    up_down = 1'b0;
    din     = '0;
    @(negedge clk);

    // Reset wins over load and holds for several edges.
    step(1'b0, 1'b1, 1'b0, 4'd7, 4'd0, "rst_edge1");
    step(1'b0, 1'b1, 1'b0, 4'd7, 4'd0, "rst_edge2");
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd1, "post_rst_up1");
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd2, "post_rst_up2");
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd3, "post_rst_up3");

    // Upward wrap through 11 -> 0.
    step(1'b1, 1'b1, 1'b0, 4'd10, 4'd10, "up_load10");
    step(1'b1, 1'b0, 1'b1, 4'd0,  4'd11, "up_11");
    step(1'b1, 1'b0, 1'b1, 4'd0,  4'd0,  "up_wrap0");
    step(1'b1, 1'b0, 1'b1, 4'd0,  4'd1,  "up_1");

    // Downward wrap through 0 -> 11.
    step(1'b1, 1'b1, 1'b1, 4'd1, 4'd1,  "dn_load1");
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd0,  "dn_0");
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd11, "dn_wrap11");
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd10, "dn_10");

    // Load priority over counting and out-of-range loads.
    step(1'b1, 1'b1, 1'b1, 4'd5,  4'd5,  "load5_over_up");
    step(1'b1, 1'b1, 1'b0, 4'd11, 4'd11, "load11");
    step(1'b1, 1'b1, 1'b1, 4'd13, 4'd0,  "load13_forced0");
    step(1'b1, 1'b1, 1'b0, 4'd15, 4'd0,  "load15_forced0");
    step(1'b1, 1'b1, 1'b0, 4'd12, 4'd0,  "load12_forced0");

    // Direction changes take effect immediately, then a mid-run reset.
    step(1'b1, 1'b1, 1'b0, 4'd4, 4'd4,  "dir_load4");
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd5,  "dir_up5");
    step(1'b1, 1'b0, 1'b1, 4'd0, 4'd6,  "dir_up6");
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd5,  "dir_dn5");
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd4,  "dir_dn4");
    step(1'b0, 1'b1, 1'b1, 4'd9, 4'd0,  "midrun_rst");
    step(1'b1, 1'b0, 1'b0, 4'd0, 4'd11, "after_rst_dn11");

    // Pseudo-random traffic against a priority-rule reference model.
    model = 4'd11;
    for (int i = 0; i < 40; i++) begin
      r_r  = ($urandom_range(0, 9) != 0);
      r_l  = ($urandom_range(0, 3) == 0);
      r_ud = 1'($urandom_range(0, 1));
      r_d  = 4'($urandom_range(0, 15));
      if (!r_r) begin
        model = 4'd0;
      end else if (r_l) begin
        model = (r_d <= 4'd11) ? r_d : 4'd0;
      end else if (r_ud) begin
        model = (model == 4'd11) ? 4'd0 : model + 4'd1;
      end else begin
        model = (model == 4'd0) ? 4'd11 : model - 4'd1;
      end
      step(r_r, r_l, r_ud, r_d, model, "random");
      checks++;
      assert (dout <= 4'd11) else begin
        errors++;
        $error("FAIL range: observed %0d expected 0..11", dout);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
